// File: rtl/stdout_tohost_monitor.sv
// stdout_tohost_monitor: snoops the RAM write port for putchar/tohost stores,
// queues stdout bytes in a small FIFO and reports the exit code once drained.
//
// Ports:
//   clk_i, arst_i         clock, asynchronous active-high reset
//   putchar_addr_i        absolute address of putchar_stdout (static)
//   tohost_addr_i         absolute address of tohost (static)
//   mem_we_i/waddr/wstrb/wdata  snooped RAM write port (RAM-relative address)
//   char_valid_o/data_o/ready_i head-of-FIFO character stream
//   char_overflow_o       sticky: a character was dropped on a full FIFO
//   char_count_o          characters accepted into the FIFO (wraps)
//   exit_valid_o          sticky: exit captured and FIFO drained
//   exit_code_o           captured exit code (unstrobed bytes read as zero)
//   exit_pass_o           exit_valid_o with a zero exit code
//
// Build option: define STDOUT_TOHOST_MON_CR_FILTER_EN to discard 0x0D bytes.

module stdout_tohost_monitor #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0,
    parameter int unsigned           FIFO_DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic [ADDR_WIDTH-1:0]   putchar_addr_i,
    input  logic [ADDR_WIDTH-1:0]   tohost_addr_i,
    input  logic                    mem_we_i,
    input  logic [ADDR_WIDTH-1:0]   mem_waddr_i,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    output logic                    char_valid_o,
    output logic [7:0]              char_data_o,
    input  logic                    char_ready_i,
    output logic                    char_overflow_o,
    output logic [31:0]             char_count_o,
    output logic                    exit_valid_o,
    output logic [DATA_WIDTH-1:0]   exit_code_o,
    output logic                    exit_pass_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PTR_WIDTH  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic run;

    logic [ADDR_WIDTH-1:0] abs_addr;
    logic                  tohost_hit;
    logic                  putchar_hit;
    logic                  push_req;

    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               drop;

    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic [DATA_WIDTH-1:0] exit_code_next;

    // Address decode
    assign abs_addr    = mem_waddr_i + MEM_BASE;
    assign tohost_hit  = run && mem_we_i && (abs_addr == tohost_addr_i);
    // tohost wins when both symbols share an address
    assign putchar_hit = run && mem_we_i && mem_wstrb_i[0]
                      && (abs_addr == putchar_addr_i) && !tohost_hit;

`ifdef STDOUT_TOHOST_MON_CR_FILTER_EN
    assign push_req = putchar_hit && (mem_wdata_i[7:0] != 8'h0D);
`else
    assign push_req = putchar_hit;
`endif

    // FIFO control: the extra pointer bit separates full from empty
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH])
                && (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
    assign pop   = !empty && char_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push  = push_req && (!full || pop);
    assign drop  = push_req && full && !pop;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_WIDTH-1:0]] <= mem_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            char_overflow_o <= 1'b0;
            char_count_o    <= '0;
        end else begin
            if (push) begin
                wr_ptr       <= wr_ptr + 1'b1;
                char_count_o <= char_count_o + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                char_overflow_o <= 1'b1;
            end
        end
    end

    assign char_valid_o = !empty;
    // Head is gated so the output reads zero whenever nothing is queued
    assign char_data_o  = char_valid_o ? fifo_mem[rd_ptr[PTR_WIDTH-1:0]]
                                       : 8'h00;

    // Exit code: strobed bytes taken from the write, others forced to zero
    always_comb begin
        exit_code_next = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (mem_wstrb_i[i]) begin
                exit_code_next[8*i +: 8] = mem_wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            exit_code_o <= '0;
        end else if (tohost_hit) begin
            exit_code_o <= exit_code_next;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (tohost_hit) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (empty) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        run          = 1'b0;
        exit_valid_o = 1'b0;
        unique case (state)
            RUN:     run          = 1'b1;
            DRAIN:   run          = 1'b0;
            DONE:    exit_valid_o = 1'b1;
            default: run          = 1'b0;
        endcase
    end

    assign exit_pass_o = exit_valid_o && (exit_code_o == '0);

endmodule

// File: tb/tb_stdout_tohost_monitor.sv
// tb_stdout_tohost_monitor: scoreboard bench for stdout_tohost_monitor.
// Expected bytes are queued at write time and compared as the DUT pops them.

module tb_stdout_tohost_monitor;

    localparam logic [63:0] BASE    = 64'h0000_0000_8000_0000;
    localparam logic [63:0] PUTCHAR = 64'h0000_0000_8000_1000;
    localparam logic [63:0] TOHOST  = 64'h0000_0000_8000_2000;

`ifdef STDOUT_TOHOST_MON_CR_FILTER_EN
    localparam bit CR_FILT = 1'b1;
`else
    localparam bit CR_FILT = 1'b0;
`endif

    logic        clk;
    logic        arst;
    logic        mem_we;
    logic [63:0] mem_waddr;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        char_overflow;
    logic [31:0] char_count;
    logic        exit_valid;
    logic [63:0] exit_code;
    logic        exit_pass;

    int errors;
    int checks;

    logic [7:0] sb[$];

    stdout_tohost_monitor #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(64),
        .MEM_BASE  (BASE),
        .FIFO_DEPTH(16)
    ) dut (
        .clk_i          (clk),
        .arst_i         (arst),
        .putchar_addr_i (PUTCHAR),
        .tohost_addr_i  (TOHOST),
        .mem_we_i       (mem_we),
        .mem_waddr_i    (mem_waddr),
        .mem_wstrb_i    (mem_wstrb),
        .mem_wdata_i    (mem_wdata),
        .char_valid_o   (char_valid),
        .char_data_o    (char_data),
        .char_ready_i   (char_ready),
        .char_overflow_o(char_overflow),
        .char_count_o   (char_count),
        .exit_valid_o   (exit_valid),
        .exit_code_o    (exit_code),
        .exit_pass_o    (exit_pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: a pop happens at the next edge
    always @(negedge clk) begin
        if (!arst && char_valid && char_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_char", {56'h0, char_data}, 64'hffff);
            end else begin
                chk("char", {56'h0, char_data}, {56'h0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [63:0] addr, input logic [7:0] strb,
                      input logic [63:0] data, input bit exp_push);
        mem_we    = 1'b1;
        mem_waddr = addr - BASE;
        mem_wstrb = strb;
        mem_wdata = data;
        if (exp_push) sb.push_back(data[7:0]);
        tick();
        mem_we = 1'b0;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        #3;
        sb.delete();
        tick();
        arst = 1'b0;
    endtask

    task automatic wait_exit(input int budget);
        int n;
        n = 0;
        while (!exit_valid && n < budget) begin
            tick();
            n++;
        end
        chk("exit_wait", {63'h0, exit_valid}, 64'h1);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        arst       = 1'b1;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wstrb  = '0;
        mem_wdata  = '0;
        char_ready = 1'b0;
        #12;
        chk("rst_valid", {63'h0, char_valid}, 64'h0);
        chk("rst_data", {56'h0, char_data}, 64'h0);
        chk("rst_ovf", {63'h0, char_overflow}, 64'h0);
        chk("rst_count", {32'h0, char_count}, 64'h0);
        chk("rst_exit_v", {63'h0, exit_valid}, 64'h0);
        chk("rst_exit_c", exit_code, 64'h0);
        chk("rst_pass", {63'h0, exit_pass}, 64'h0);
        do_reset();

        // Streaming with consumer ready, one cycle latency each
        char_ready = 1'b1;
        wr(PUTCHAR, 8'h01, 64'h48, 1'b1);
        @(negedge clk);
        chk("lat_h", {63'h0, char_valid}, 64'h1);
        #4;
        wr(PUTCHAR, 8'h01, 64'h69, 1'b1);
        @(negedge clk);
        chk("lat_i", {63'h0, char_valid}, 64'h1);
        #4;
        wr(PUTCHAR, 8'h01, 64'h0A, 1'b1);
        @(negedge clk);
        chk("lat_nl", {63'h0, char_valid}, 64'h1);
        #4;
        ticks(3);
        chk("t1_count", {32'h0, char_count}, 64'd3);
        chk("t1_empty", {63'h0, char_valid}, 64'h0);
        chk("t1_sb", sb.size(), 0);

        // Overflow with consumer stalled
        do_reset();
        char_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr(PUTCHAR, 8'h01, 64'(8'h30 + i), i < 16);
        end
        chk("ovf_flag", {63'h0, char_overflow}, 64'h1);
        chk("ovf_count", {32'h0, char_count}, 64'd16);
        chk("ovf_head", {56'h0, char_data}, 64'h30);
        ticks(2);
        chk("ovf_stable", {56'h0, char_data}, 64'h30);
        char_ready = 1'b1;
        ticks(20);
        chk("ovf_sb", sb.size(), 0);
        chk("ovf_drained", {63'h0, char_valid}, 64'h0);

        // Byte 0 not strobed: no push
        do_reset();
        char_ready = 1'b1;
        wr(PUTCHAR, 8'h02, 64'h5500, 1'b0);
        ticks(2);
        chk("strb_count", {32'h0, char_count}, 64'd0);
        chk("strb_valid", {63'h0, char_valid}, 64'h0);

        // tohost with empty FIFO, partial strobes
        wr(TOHOST, 8'h0F, 64'hDEADBEEF_00000001, 1'b0);
        chk("th_drain", {63'h0, exit_valid}, 64'h0);
        tick();
        chk("th_done", {63'h0, exit_valid}, 64'h1);
        chk("th_code", exit_code, 64'h1);
        chk("th_pass", {63'h0, exit_pass}, 64'h0);
        wr(TOHOST, 8'hFF, 64'h0, 1'b0);
        ticks(2);
        chk("th2_code", exit_code, 64'h1);
        chk("th2_pass", {63'h0, exit_pass}, 64'h0);

        // tohost with characters pending
        do_reset();
        char_ready = 1'b0;
        wr(PUTCHAR, 8'h01, 64'h61, 1'b1);
        wr(PUTCHAR, 8'h01, 64'h62, 1'b1);
        wr(PUTCHAR, 8'h01, 64'h63, 1'b1);
        wr(TOHOST, 8'hFF, 64'h0, 1'b0);
        wr(PUTCHAR, 8'h01, 64'h77, 1'b0);
        ticks(3);
        chk("pend_exit", {63'h0, exit_valid}, 64'h0);
        chk("pend_count", {32'h0, char_count}, 64'd3);
        char_ready = 1'b1;
        // Pops at next 3 edges; DONE at the edge after the last pop
        ticks(4);
        chk("pend_done", {63'h0, exit_valid}, 64'h1);
        chk("pend_pass", {63'h0, exit_pass}, 64'h1);
        chk("pend_sb", sb.size(), 0);

        // Carriage return handling
        do_reset();
        char_ready = 1'b1;
        wr(PUTCHAR, 8'h01, 64'h0D, !CR_FILT);
        wr(PUTCHAR, 8'h01, 64'h41, 1'b1);
        ticks(3);
        chk("cr_count", {32'h0, char_count}, CR_FILT ? 64'd1 : 64'd2);
        chk("cr_sb", sb.size(), 0);

        // Asynchronous reset during DRAIN
        do_reset();
        char_ready = 1'b0;
        wr(PUTCHAR, 8'h01, 64'h31, 1'b0);
        wr(PUTCHAR, 8'h01, 64'h32, 1'b0);
        wr(TOHOST, 8'hFF, 64'h5, 1'b0);
        #2;
        arst = 1'b1;
        #1;
        chk("ar_valid", {63'h0, char_valid}, 64'h0);
        chk("ar_count", {32'h0, char_count}, 64'h0);
        chk("ar_code", exit_code, 64'h0);
        chk("ar_exit", {63'h0, exit_valid}, 64'h0);
        tick();
        arst = 1'b0;
        char_ready = 1'b1;
        wr(TOHOST, 8'hFF, 64'h0, 1'b0);
        tick();
        chk("ar_run_exit", {63'h0, exit_valid}, 64'h1);
        wait_exit(10);
        chk("ar_pass", {63'h0, exit_pass}, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
